// File: rtl/pipeline_register_memwb_ctl.sv
// pipeline_register_memwb_ctl
//   MEM/WB pipeline register for the MIPS pipeline. Captures the MEM-stage
//   control and data, selects the write-back value, flags whether the WB stage
//   may act as a forwarding source, and keeps retire / WB-stall counters.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall_i / flush_i     hold stage contents / load a bubble (flush wins)
//   cnt_clear_i           synchronous clear of both performance counters
//   *_i                   MEM-stage slot contents (valid, controls, dest, data)
//   *_o                   registered copies of the *_i inputs
//   wb_data_o             write-back value chosen from the registered stage
//   fwd_valid_o           WB stage holds a valid write to a non-zero register
//   retire_cnt_o          valid instructions loaded into WB (wrapping)
//   stall_cnt_o           cycles a valid WB instruction was held (saturating)
module pipeline_register_memwb_ctl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      cnt_clear_i,
    input  logic                      valid_i,
    input  logic                      mem_to_reg_i,
    input  logic                      link_i,
    input  logic                      reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] write_register_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus_4_i,
    input  logic [DATA_WIDTH-1:0]     read_data_mmry_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    output logic                      valid_o,
    output logic                      mem_to_reg_o,
    output logic                      link_o,
    output logic                      reg_write_o,
    output logic [REG_ADDR_WIDTH-1:0] write_register_o,
    output logic [DATA_WIDTH-1:0]     pc_plus_4_o,
    output logic [DATA_WIDTH-1:0]     read_data_mmry_o,
    output logic [DATA_WIDTH-1:0]     alu_result_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      fwd_valid_o,
    output logic [CNT_WIDTH-1:0]      retire_cnt_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    logic load;
    logic stall_hit;

    // A load happens only when neither flush nor stall claims the edge.
    assign load      = !flush_i && !stall_i;
    assign stall_hit = stall_i && !flush_i && valid_o;

    // Stage register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_o          <= 1'b0;
            mem_to_reg_o     <= 1'b0;
            link_o           <= 1'b0;
            reg_write_o      <= 1'b0;
            write_register_o <= '0;
            pc_plus_4_o      <= '0;
            read_data_mmry_o <= '0;
            alu_result_o     <= '0;
        end else if (!stall_i) begin
            valid_o          <= valid_i;
            mem_to_reg_o     <= mem_to_reg_i;
            link_o           <= link_i;
            // An invalid slot must never write the register file.
            reg_write_o      <= reg_write_i & valid_i;
            write_register_o <= write_register_i;
            pc_plus_4_o      <= pc_plus_4_i;
            read_data_mmry_o <= read_data_mmry_i;
            alu_result_o     <= alu_result_i;
        end
    end

    // Performance counters; clear beats any same-edge increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear_i) begin
            retire_cnt_o <= '0;
            stall_cnt_o  <= '0;
        end else begin
            if (load && valid_i) begin
                retire_cnt_o <= retire_cnt_o + 1'b1;
            end
            if (stall_hit && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

    // Link (jal) takes precedence over a memory load result.
    always_comb begin
        wb_data_o = alu_result_o;
        if (link_o) begin
            wb_data_o = pc_plus_4_o;
        end else if (mem_to_reg_o) begin
            wb_data_o = read_data_mmry_o;
        end
    end

    // r0 is hardwired to zero, so it is never a forwarding source.
    assign fwd_valid_o = valid_o && reg_write_o && (write_register_o != '0);

endmodule
